rrobin_burst_arbiter: RTL and testbench

//  Round-robin arbiter sharing one resource among NREQ requesters with burst-limited grant tenure.

---
 rtl/rrarb_pkg.sv | 38 +++
 rtl/rrarb_pick.sv | 28 ++
 rtl/rrobin_burst_arbiter.sv | 142 ++++++++++++++
 tb/tb_rrobin_burst_arbiter.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/rrarb_pkg.sv
// rrarb_pkg: shared types and helpers for the round-robin burst arbiter.
//   rrarb_state_t : FSM state encoding (IDLE, HOLD, TURN)
//   rr_pick       : rotating-priority search, width supplied by the caller
//                   (nreq <= RR_MAX_REQ)
package rrarb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HOLD = 2'd1,
      TURN = 2'd2
   } rrarb_state_t;

   localparam int unsigned RR_MAX_REQ = 32;
   localparam int unsigned RR_IDX_W   = $clog2(RR_MAX_REQ);

   // First set bit scanning ptr, ptr+1, ... wrapping mod nreq; 0 if none.
   function automatic int unsigned rr_pick(
      input logic [RR_MAX_REQ-1:0] req,
      input int unsigned           ptr,
      input int unsigned           nreq
   );
      int unsigned idx;
      logic        found;
      rr_pick = 0;
      found   = 1'b0;
      for (int unsigned k = 0; k < RR_MAX_REQ; k++) begin
         if ((k < nreq) && !found) begin
            idx = ptr + k;
            if (idx >= nreq) idx = idx - nreq;
            if (req[idx[RR_IDX_W-1:0]]) begin
               rr_pick = idx;
               found   = 1'b1;
            end
         end
      end
   endfunction

endpackage

// File: rtl/rrarb_pick.sv
// rrarb_pick: combinational rotating-priority picker.
//   req    in  NREQ  request vector
//   ptr    in  IDW   index with highest priority this round
//   win    out NREQ  one-hot winner (0 when no request)
//   win_id out IDW   winner index (0 when no request)
//   any    out 1     at least one request present
module rrarb_pick
   import rrarb_pkg::*;
#(
   parameter  int unsigned NREQ = 4,
   localparam int unsigned IDW  = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  ptr,
   output logic [NREQ-1:0] win,
   output logic [IDW-1:0]  win_id,
   output logic            any
);

   // Search is delegated to the package helper; one-hot derived from the index.
   always_comb begin
      any    = |req;
      win_id = IDW'(rr_pick(RR_MAX_REQ'(req), 32'(ptr), NREQ));
      win    = '0;
      if (any) win[win_id] = 1'b1;
   end

endmodule

// File: rtl/rrobin_burst_arbiter.sv
// rrobin_burst_arbiter: round-robin arbiter with burst-limited grant tenure
// and a one-cycle dead cycle between successive owners.
//   clock    in  1     posedge clock
//   reset    in  1     asynchronous, active-high
//   req      in  NREQ  request vector
//   lock     in  1     (RRARB_LOCK_EN only) hold the current owner past BURST
//   gnt      out NREQ  registered one-hot grant
//   gnt_vld  out 1     |gnt
//   gnt_id   out IDW   owner index, 0 when idle
// Optional feature macro: RRARB_LOCK_EN (adds the lock port).
module rrobin_burst_arbiter
   import rrarb_pkg::*;
#(
   parameter  int unsigned NREQ  = 4,
   parameter  int unsigned BURST = 8,
   localparam int unsigned IDW   = $clog2(NREQ),
   localparam int unsigned CW    = $clog2(BURST + 1)
) (
   input  logic            clock,
   input  logic            reset,
   input  logic [NREQ-1:0] req,
`ifdef RRARB_LOCK_EN
   input  logic            lock,
`endif
   output logic [NREQ-1:0] gnt,
   output logic            gnt_vld,
   output logic [IDW-1:0]  gnt_id
);

   rrarb_state_t    state_q, state_d;
   logic [IDW-1:0]  ptr_q,   ptr_d;
   logic [CW-1:0]   cnt_q,   cnt_d;
   logic [NREQ-1:0] gnt_q,   gnt_d;
   logic [IDW-1:0]  id_q,    id_d;
   logic            vld_q,   vld_d;

   logic [NREQ-1:0] win;
   logic [IDW-1:0]  win_id;
   logic            any;
   logic            owner_req_c;
   logic            others_c;
   logic            lock_hold_c;
   logic            expire_c;

   rrarb_pick #(
      .NREQ (NREQ)
   ) u_pick (
      .req    (req),
      .ptr    (ptr_q),
      .win    (win),
      .win_id (win_id),
      .any    (any)
   );

   // Lock only matters in HOLD; it is gated there by the owner's own request.
`ifdef RRARB_LOCK_EN
   assign lock_hold_c = lock;
`else
   assign lock_hold_c = 1'b0;
`endif

   // Burst expiry needs a full burst and at least one other waiting requester.
   always_comb begin
      owner_req_c = req[id_q];
      others_c    = |(req & ~gnt_q);
      expire_c    = (cnt_q == CW'(BURST)) && others_c && !lock_hold_c;
   end

   // Next-state and next-output logic.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      gnt_d   = gnt_q;
      id_d    = id_q;
      vld_d   = vld_q;

      case (state_q)
         IDLE, TURN: begin
            if (any) begin
               state_d = HOLD;
               gnt_d   = win;
               id_d    = win_id;
               vld_d   = 1'b1;
               cnt_d   = CW'(1);
               ptr_d   = (win_id == IDW'(NREQ - 1)) ? '0 : win_id + IDW'(1);
            end else begin
               state_d = IDLE;
               gnt_d   = '0;
               id_d    = '0;
               vld_d   = 1'b0;
               cnt_d   = '0;
            end
         end

         HOLD: begin
            if (!owner_req_c || expire_c) begin
               state_d = TURN;
               gnt_d   = '0;
               id_d    = '0;
               vld_d   = 1'b0;
               cnt_d   = '0;
            end else if (cnt_q != CW'(BURST)) begin
               cnt_d   = cnt_q + CW'(1);
            end
         end

         default: begin
            state_d = IDLE;
            ptr_d   = '0;
            cnt_d   = '0;
            gnt_d   = '0;
            id_d    = '0;
            vld_d   = 1'b0;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         cnt_q   <= '0;
         gnt_q   <= '0;
         id_q    <= '0;
         vld_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         gnt_q   <= gnt_d;
         id_q    <= id_d;
         vld_q   <= vld_d;
      end
   end

   assign gnt     = gnt_q;
   assign gnt_vld = vld_q;
   assign gnt_id  = id_q;

endmodule

// File: tb/tb_rrobin_burst_arbiter.sv
// tb_rrobin_burst_arbiter: directed scenarios plus random request traffic,
// compared every cycle against an owner/tenure reference model.
module tb_rrobin_burst_arbiter;

   localparam int unsigned NREQ  = 4;
   localparam int unsigned BURST = 8;
   localparam int unsigned IDW   = 2;
   localparam int          BOUND = (NREQ - 1) * (BURST + 1) + 1;

   logic            clock = 1'b0;
   logic            reset = 1'b0;
   logic [NREQ-1:0] req   = '0;
`ifdef RRARB_LOCK_EN
   logic            lock  = 1'b0;
`endif
   logic [NREQ-1:0] gnt;
   logic            gnt_vld;
   logic [IDW-1:0]  gnt_id;

   int errors = 0;
   int checks = 0;

   // Reference model: current owner (-1 = none), its tenure, next priority.
   int m_owner;
   int m_tenure;
   int m_ptr;
   int waitc [NREQ];

   always #5 clock = ~clock;

   rrobin_burst_arbiter #(
      .NREQ  (NREQ),
      .BURST (BURST)
   ) dut (
      .clock   (clock),
      .reset   (reset),
      .req     (req),
`ifdef RRARB_LOCK_EN
      .lock    (lock),
`endif
      .gnt     (gnt),
      .gnt_vld (gnt_vld),
      .gnt_id  (gnt_id)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int exp_gnt();
      return (m_owner >= 0) ? (1 << m_owner) : 0;
   endfunction

   task automatic model_reset();
      m_owner  = -1;
      m_tenure = 0;
      m_ptr    = 0;
      for (int i = 0; i < NREQ; i++) waitc[i] = 0;
   endtask

   // One clock edge of the arbitration rules, applied to sampled requests rv.
   task automatic model_edge(input int rv, input bit lk);
      int others;
      if (m_owner >= 0) begin
         others = rv & ~(1 << m_owner);
         if (((rv >> m_owner) & 1) == 0)
            m_owner = -1;
         else if (m_tenure >= BURST && others != 0 && !lk)
            m_owner = -1;
         else
            m_tenure++;
      end else if (rv != 0) begin
         for (int k = 0; k < NREQ; k++) begin
            if (m_owner < 0 && ((rv >> ((m_ptr + k) % NREQ)) & 1) == 1)
               m_owner = (m_ptr + k) % NREQ;
         end
         m_ptr    = (m_owner + 1) % NREQ;
         m_tenure = 1;
      end
   endtask

   // Drive requests, take one edge, then compare everything 1 time unit later.
   task automatic step(input logic [NREQ-1:0] r, input bit lk);
      int rv;
      rv  = int'(r);
      req = r;
`ifdef RRARB_LOCK_EN
      lock = lk;
`endif
      @(posedge clock);
      model_edge(rv, lk);
      #1;
      chk("gnt",     32'(gnt),     32'(exp_gnt()));
      chk("gnt_vld", 32'(gnt_vld), 32'(m_owner >= 0));
      chk("gnt_id",  32'(gnt_id),  32'((m_owner >= 0) ? m_owner : 0));
      chk("onehot0", 32'($onehot0(gnt)), 32'd1);
      chk("gnt_without_req", 32'(gnt & ~r), 32'd0);
      for (int i = 0; i < NREQ; i++) begin
         if (((rv >> i) & 1) == 1 && !gnt[i]) waitc[i]++;
         else                                  waitc[i] = 0;
         if (((rv >> i) & 1) == 1 && !lk)
            chk("starve_bound", 32'(waitc[i] <= BOUND), 32'd1);
      end
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      req   = '0;
`ifdef RRARB_LOCK_EN
      lock  = 1'b0;
`endif
      model_reset();
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
   endtask

   initial begin
      model_reset();
      #1 reset = 1'b1;
      #1;
      chk("reset_gnt",     32'(gnt),     32'd0);
      chk("reset_gnt_vld", 32'(gnt_vld), 32'd0);
      chk("reset_gnt_id",  32'(gnt_id),  32'd0);
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset = 1'b0;

      // Single uncontended requester keeps the grant indefinitely.
      step(4'b0010, 1'b0);
      chk("uncont_first_gnt", 32'(gnt), 32'h2);
      chk("uncont_first_id",  32'(gnt_id), 32'd1);
      repeat (29) step(4'b0010, 1'b0);
      chk("uncont_after_30", 32'(gnt), 32'h2);
      repeat (2) step(4'b0000, 1'b0);

      // All requesting: 8-cycle bursts rotating with a dead cycle between.
      repeat (40) step(4'b1111, 1'b0);
      repeat (2) step(4'b0000, 1'b0);

      // Owner 0 drops during its 3rd grant cycle.
      apply_reset();
      repeat (3) step(4'b0011, 1'b0);
      chk("drop_owner0", 32'(gnt), 32'h1);
      step(4'b0010, 1'b0);
      chk("drop_turn", 32'(gnt), 32'h0);
      step(4'b0010, 1'b0);
      chk("drop_next", 32'(gnt), 32'h2);
      repeat (2) step(4'b0000, 1'b0);

      // Pointer at 3 with requests 3 and 0: wrap-around order.
      step(4'b0100, 1'b0);
      repeat (2) step(4'b0000, 1'b0);
      step(4'b1001, 1'b0);
      chk("wrap_first", 32'(gnt), 32'h8);
      repeat (8) step(4'b1001, 1'b0);
      chk("wrap_turn", 32'(gnt), 32'h0);
      step(4'b1001, 1'b0);
      chk("wrap_second", 32'(gnt), 32'h1);
      repeat (2) step(4'b0000, 1'b0);

      // Asynchronous reset while requester 2 owns the grant.
      step(4'b0100, 1'b0);
      step(4'b0100, 1'b0);
      chk("pre_reset_gnt", 32'(gnt), 32'h4);
      #2 reset = 1'b1;
      #1;
      chk("async_gnt",     32'(gnt),     32'd0);
      chk("async_gnt_vld", 32'(gnt_vld), 32'd0);
      chk("async_gnt_id",  32'(gnt_id),  32'd0);
      model_reset();
      @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      step(4'b1010, 1'b0);
      chk("ptr_after_reset", 32'(gnt), 32'h2);
      repeat (2) step(4'b0000, 1'b0);

`ifdef RRARB_LOCK_EN
      // Lock extends owner 0 beyond its burst; release expires it next edge.
      apply_reset();
      repeat (12) step(4'b0011, 1'b1);
      chk("lock_held", 32'(gnt), 32'h1);
      step(4'b0011, 1'b0);
      chk("lock_release_turn", 32'(gnt), 32'h0);
      step(4'b0011, 1'b0);
      chk("lock_next_owner", 32'(gnt), 32'h2);
      repeat (2) step(4'b0000, 1'b0);
`endif

      // Random traffic: each request bit flips with low probability.
      begin
         logic [NREQ-1:0] r;
         r = '0;
         for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < NREQ; i++)
               if ($urandom_range(0, 7) == 0) r[i] = ~r[i];
            if ($urandom_range(0, 99) == 0) r = '1;
            step(r, 1'b0);
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
